param_parallel_sorter: RTL
==========================

// Module: param_parallel_sorter
// PURPOSE
//  Parametrised successor of the fixed 8x8-bit parallel sorter. Sorts N_ELEM unsigned WIDTH-bit
//  words with an odd-even transposition network, one phase per clock, under a valid/ready
//  handshake on both sides. Direction is selectable per job (ascending/descending). Ties never
//  swap, so the sort is stable. Sits between a producer and a consumer of whole arrays.
// PARAMETERS
//  WIDTH   8  bits per element, >=1
//  N_ELEM  8  elements per array, >=2, any value (odd allowed)
// PORTS
//  clk           in   1               clock, all logic on rising edge
//  reset         in   1               synchronous, active-high
//  in_valid      in   1               mixed_array/descending valid
//  in_ready      out  1               block can accept a job
//  descending    in   1               0: ascending, 1: descending; sampled with the job
//  mixed_array   in   WIDTH x N_ELEM  unsorted input array
//  out_valid     out  1               sorted_array holds a finished result
//  out_ready     in   1               consumer takes the result
//  sorted_array  out  WIDTH x N_ELEM  result; element 0 = min (asc) or max (desc)
//  busy          out  1               high in SORT or DONE
//  sorted_index  out  IW x N_ELEM     SORT_INDEX_EN only; IW = $clog2(N_ELEM)
// BEHAVIOUR
//  - Reset (sync, active-high; wins over all else): state IDLE, in_ready=1, out_valid=0, busy=0,
//    sorted_array all zero, phase counter 0, sorted_index all zero. A job in flight is discarded.
//  - FSM IDLE -> SORT -> DONE -> IDLE.
//    IDLE: in_ready=1. Edge with in_valid=1: load mixed_array and descending into working regs,
//      phase=0, go SORT. in_valid=0: stay.
//    SORT: in_ready=0, busy=1. Each edge applies phase p: p even compares pairs (0,1),(2,3)...;
//      p odd compares (1,2),(3,4)...; unpaired end element holds. Swap only if strictly out of
//      order (asc: a[i]>a[i+1]; desc: a[i]<a[i+1]). After phase N_ELEM-1, go DONE.
//    DONE: out_valid=1, sorted_array stable and unchanged until the handshake. Edge with
//      out_ready=1: out_valid->0, go IDLE. out_ready held low: stay indefinitely.
//  - Latency: acceptance edge E, out_valid high from edge E+N_ELEM (exactly N_ELEM SORT cycles,
//    independent of data; no early exit). Throughput: one job per N_ELEM+2 cycles min.
//  - in_valid while not in_ready is ignored (producer holds it). out_ready while out_valid=0
//    is ignored. in_ready is low in DONE, so no accept overlaps the output handshake.
//  - Comparisons unsigned, full WIDTH; no width growth. sorted_array drives working regs
//    directly (intermediate values visible during SORT; valid only with out_valid).
//  - Phase counter width $clog2(N_ELEM+1); wraps never occur (reset to 0 on each load).
// CONFIGURATION
//  SORT_INDEX_EN defined: each element carries its original position (0..N_ELEM-1) tagged at
//   load and swapped with it; sorted_index[k] = input index of sorted_array[k]. Ties keep
//   ascending original index (stable). Reset value all zero.
//  SORT_INDEX_EN undefined: sorted_index port and tag registers absent; data behaviour identical.
// TESTING
//  1 N_ELEM=8, asc, {9,3,250,0,77,3,128,1} -> after 8 SORT cycles out_valid=1,
//    sorted_array={0,1,3,3,9,77,128,250}; with SORT_INDEX_EN sorted_index={3,7,1,5,0,4,6,2}.
//  2 Same input, descending=1 -> {250,128,77,9,3,3,1,0}; index {2,6,4,0,1,5,7,3} (stable ties).
//  3 Reverse-ordered worst case {255..248}, asc -> {248..255} exactly at edge E+8; out_ready held
//    low 5 cycles -> out_valid and data stable, in_ready=0 throughout; out_ready=1 -> IDLE.
//  4 Back-to-back: in_valid held high, out_ready=1 -> jobs accepted every N_ELEM+2 cycles,
//    no job lost or duplicated over 100 random arrays ($urandom, SEED) vs. reference model.
//  5 reset asserted in SORT phase 3 -> next cycle IDLE, in_ready=1, out_valid=0, array zero;
//    new job after release sorts correctly.
//  6 N_ELEM=5, WIDTH=4, all-equal {7,7,7,7,7} and {15,0,15,0,15} -> unchanged / {0,0,15,15,15}.

Source files
------------

// File: rtl/param_parallel_sorter.sv
// -----------------------------------------------------------------------------
// param_parallel_sorter
//
// Sorts N_ELEM unsigned WIDTH-bit words with an odd-even transposition network.
// The network applies one phase per clock, and a job always takes N_ELEM phases.
// Only strictly out-of-order neighbours are swapped, so equal words keep their
// input order and the sort is stable. The sort direction is captured with each
// job.
//
// Optional feature macro: SORT_INDEX_EN
//   When defined, each word carries a tag holding its original position.
//   The tag moves with the word, and the tags are presented on sorted_index.
//
// Ports
//   clk          : clock; all logic runs on the rising edge
//   reset        : synchronous, active-high
//   in_valid     : mixed_array and descending are valid
//   in_ready     : block is IDLE and can accept a job
//   descending   : 0 = ascending, 1 = descending; sampled with the job
//   mixed_array  : input array; element k is at [k*WIDTH +: WIDTH]
//   out_valid    : sorted_array holds a finished result
//   out_ready    : consumer takes the result
//   sorted_array : working registers; element 0 is the min (asc) or the max (desc)
//   busy         : high in SORT or DONE
//   sorted_index : (SORT_INDEX_EN) original index of each sorted element
// -----------------------------------------------------------------------------
module param_parallel_sorter #(
    parameter int WIDTH  = 8,
    parameter int N_ELEM = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       descending,
    input  logic [N_ELEM*WIDTH-1:0]    mixed_array,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_ELEM*WIDTH-1:0]    sorted_array,
    output logic                       busy
`ifdef SORT_INDEX_EN
    ,
    output logic [N_ELEM*$clog2(N_ELEM)-1:0] sorted_index
`endif
);

    localparam int PW = $clog2(N_ELEM + 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(N_ELEM - 1);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t                        state_q, state_d;
    logic [PW-1:0]                 phase_q, phase_d;
    logic                          desc_q, desc_d;
    logic [N_ELEM-1:0][WIDTH-1:0]  data_q, data_d, net_data;
    logic [N_ELEM-2:0]             pair_swap;

    // Compare-exchange stage for the current phase. Pair (gi, gi+1) takes part
    // only when gi has the same parity as the phase number.
    for (genvar gi = 0; gi < N_ELEM - 1; gi++) begin : g_pair
        logic active;
        assign active        = (phase_q[0] == ((gi % 2) == 1));
        assign pair_swap[gi] = active && (desc_q ? (data_q[gi] < data_q[gi+1])
                                                 : (data_q[gi] > data_q[gi+1]));
    end

    // Each element belongs to at most one active pair in a phase. Its next
    // value therefore comes from the right neighbour, the left neighbour, or
    // itself.
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
        if (gi == 0) begin : g_first
            assign net_data[gi] = pair_swap[gi] ? data_q[gi+1] : data_q[gi];
        end else if (gi == N_ELEM - 1) begin : g_last
            assign net_data[gi] = pair_swap[gi-1] ? data_q[gi-1] : data_q[gi];
        end else begin : g_mid
            assign net_data[gi] = pair_swap[gi]   ? data_q[gi+1] :
                                  pair_swap[gi-1] ? data_q[gi-1] : data_q[gi];
        end
    end

`ifdef SORT_INDEX_EN
    localparam int IW = $clog2(N_ELEM);
    logic [N_ELEM-1:0][IW-1:0] tag_q, tag_d, net_tag, init_tag;

    // Tags follow exactly the same swap decisions as the data words.
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_tag
        assign init_tag[gi] = IW'(gi);
        if (gi == 0) begin : g_first
            assign net_tag[gi] = pair_swap[gi] ? tag_q[gi+1] : tag_q[gi];
        end else if (gi == N_ELEM - 1) begin : g_last
            assign net_tag[gi] = pair_swap[gi-1] ? tag_q[gi-1] : tag_q[gi];
        end else begin : g_mid
            assign net_tag[gi] = pair_swap[gi]   ? tag_q[gi+1] :
                                 pair_swap[gi-1] ? tag_q[gi-1] : tag_q[gi];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    always_comb begin
        tag_d = tag_q;
        if (state_q == IDLE && in_valid) begin
            tag_d = init_tag;
        end else if (state_q == SORT) begin
            tag_d = net_tag;
        end
    end

    assign sorted_index = tag_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            desc_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            desc_q  <= desc_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        desc_d  = desc_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = mixed_array;
                    desc_d  = descending;
                    phase_d = '0;
                    state_d = SORT;
                end
            end
            SORT: begin
                data_d = net_data;
                // There is no early exit; every job runs all N_ELEM phases.
                if (phase_q == LAST_PHASE) begin
                    state_d = DONE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign sorted_array = data_q;

endmodule
